// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries IF predictions to EX, flushes on mispredict, trains BTB/PHT.
// Optional statistics counters are built when BRU_PERF_EN is defined.
module branch_resolve_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic        if_pred_taken,
    input  logic [31:0] if_pred_pc,
    input  logic        stall,
    input  logic        ex_is_control_flow,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic        bp_is_control_flow,
    output logic        bp_is_correct,
    output logic [31:0] bp_pc_to_update,
    output logic [31:0] bp_branch_target,
    output logic [31:0] perf_cf_count,
    output logic [31:0] perf_mispredict_count
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } slot_t;

    slot_t       ifid;
    slot_t       idex;
    logic [31:0] pc_plus4;
    logic [31:0] actual_next;
    logic        cf_mis;
    logic        alias_mis;
    logic        train;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ifid <= '{valid: 1'b0, pc: RESET_PC, pred_taken: 1'b0, pred_pc: RESET_PC};
            idex <= '{valid: 1'b0, pc: RESET_PC, pred_taken: 1'b0, pred_pc: RESET_PC};
        end else if (flush) begin
            ifid.valid <= 1'b0;
            idex.valid <= 1'b0;
        end else if (stall) begin
            idex.valid <= 1'b0;
        end else begin
            ifid <= '{valid: if_valid, pc: if_pc,
                      pred_taken: if_pred_taken, pred_pc: if_pred_pc};
            idex <= ifid;
        end
    end

    assign ex_valid    = idex.valid;
    assign ex_pc       = idex.pc;
    assign pc_plus4    = idex.pc + 32'd4;
    assign actual_next = ex_taken ? ex_target : pc_plus4;

    // A right direction with a wrong taken target still needs a redirect.
    assign cf_mis = ex_is_control_flow &&
                    ((idex.pred_taken != ex_taken) ||
                     (ex_taken && (idex.pred_pc != ex_target)));
    assign alias_mis = !ex_is_control_flow && idex.pred_taken;

    assign flush = idex.valid && (cf_mis || alias_mis);

    always_comb begin
        redirect_pc = RESET_PC;
        if (flush) begin
            redirect_pc = alias_mis ? pc_plus4 : actual_next;
        end
    end

    assign train = idex.valid && ex_is_control_flow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bp_is_control_flow <= 1'b0;
            bp_is_correct      <= 1'b0;
            bp_pc_to_update    <= RESET_PC;
            bp_branch_target   <= 32'h0;
        end else begin
            bp_is_control_flow <= train;
            if (train) begin
                bp_is_correct    <= (idex.pred_taken == ex_taken);
                bp_pc_to_update  <= idex.pc;
                bp_branch_target <= ex_target;
            end
        end
    end

`ifdef BRU_PERF_EN
    logic [31:0] perf_cf_q;
    logic [31:0] perf_mis_q;

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_cf_q  <= 32'h0;
            perf_mis_q <= 32'h0;
        end else begin
            if (bp_is_control_flow && (perf_cf_q != 32'hFFFF_FFFF)) begin
                perf_cf_q <= perf_cf_q + 32'd1;
            end
            if (flush && (perf_mis_q != 32'hFFFF_FFFF)) begin
                perf_mis_q <= perf_mis_q + 32'd1;
            end
        end
    end

    assign perf_cf_count         = perf_cf_q;
    assign perf_mispredict_count = perf_mis_q;
`else
    assign perf_cf_count         = 32'h0;
    assign perf_mispredict_count = 32'h0;
`endif

endmodule
